// File: rtl/message_bit_serializer_pkg.sv
// Shared types for the message bit serializer: FSM state encoding and byte width.
package message_bit_serializer_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/message_bit_serializer_if.sv
// Byte-in / bit-out handshake bundle between the message feeder and the serializer.
interface message_bit_serializer_if #(
    parameter int unsigned LEN_W = 16
);
    import message_bit_serializer_pkg::*;

    logic             in_start;
    logic [LEN_W-1:0] in_length;
    byte_t            in_byte;
    logic             in_byte_valid;
    logic             out_byte_ready;
    logic             in_bit_req;
    logic             out_message;
    logic             out_bit_valid;
    logic             out_underrun;
    logic             out_done;
    logic             out_busy;

    modport master (
        output in_start, in_length, in_byte, in_byte_valid, in_bit_req,
        input  out_byte_ready, out_message, out_bit_valid, out_underrun, out_done, out_busy
    );

    modport slave (
        input  in_start, in_length, in_byte, in_byte_valid, in_bit_req,
        output out_byte_ready, out_message, out_bit_valid, out_underrun, out_done, out_busy
    );

endinterface

// File: rtl/message_bit_serializer_fifo.sv
// Synchronous byte FIFO with show-ahead head output; pointers carry a wrap bit for full/empty.
module sync_byte_fifo
    import message_bit_serializer_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  byte_t din,
    output byte_t head,
    output logic  full,
    output logic  empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    byte_t       mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/message_bit_serializer.sv
// Serialises buffered message bytes into one registered bit per sample request,
// bounded by a byte length latched at start.
module message_bit_serializer
    import message_bit_serializer_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned LEN_W     = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic                      in_clk,
    input logic                      in_rst,
    message_bit_serializer_if.slave  bus
);
    state_t           state;
    state_t           state_nx;
    byte_t            shift_q;
    logic [3:0]       bit_cnt;
    logic [LEN_W-1:0] bytes_left;
    logic             message_q;
    logic             bit_valid_q;
    logic             underrun_q;

    byte_t            fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             start_ok;
    logic             serve;
    logic             cur_bit;

    sync_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (in_clk),
        .rst   (in_rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.in_byte),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state       <= S_IDLE;
            shift_q     <= '0;
            bit_cnt     <= '0;
            bytes_left  <= '0;
            message_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state       <= state_nx;
            bit_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            if (start_ok) bytes_left <= bus.in_length;
            if (fifo_pop) begin
                shift_q <= fifo_head;
                bit_cnt <= 4'd8;
                if (bytes_left != '0) bytes_left <= bytes_left - LEN_W'(1);
            end
            if (bus.in_bit_req) begin
                if (serve) begin
                    message_q   <= cur_bit;
                    bit_valid_q <= 1'b1;
                    shift_q     <= MSB_FIRST ? {shift_q[BYTE_W-2:0], 1'b0}
                                             : {1'b0, shift_q[BYTE_W-1:1]};
                    if (bit_cnt != '0) bit_cnt <= bit_cnt - 4'd1;
                end else begin
                    message_q  <= 1'b0;
                    underrun_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (bus.in_start)
                                state_nx = (bus.in_length == '0) ? S_DONE : S_LOAD;
            S_LOAD:         if (!fifo_empty) state_nx = S_SHIFT;
            S_SHIFT:        if (bus.in_bit_req && bit_cnt == 4'd1)
                                state_nx = (bytes_left == '0) ? S_DONE : S_LOAD;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        start_ok           = bus.in_start && (state == S_IDLE || state == S_DONE);
        fifo_pop           = (state == S_LOAD) && !fifo_empty;
        fifo_push          = bus.in_byte_valid && !fifo_full;
        serve              = (state == S_SHIFT);
        cur_bit            = MSB_FIRST ? shift_q[BYTE_W-1] : shift_q[0];
        bus.out_byte_ready = !fifo_full;
        bus.out_message    = message_q;
        bus.out_bit_valid  = bit_valid_q;
        bus.out_underrun   = underrun_q;
        bus.out_done       = (state == S_DONE);
        bus.out_busy       = (state == S_LOAD) || (state == S_SHIFT);
    end

endmodule

// File: tb/tb_message_bit_serializer.sv
// Scoreboard bench: MSB-first and LSB-first serializers share one stimulus stream.
module tb_message_bit_serializer;
    import message_bit_serializer_pkg::*;

    typedef struct packed {
        logic under;
        logic bitv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] length = '0;
    byte_t       byte_in = '0;
    logic        valid = 1'b0;
    logic        req = 1'b0;

    int checks = 0;
    int failures = 0;
    exp_t qm[$];
    exp_t ql[$];

    always #5 clk = ~clk;

    message_bit_serializer_if #(.LEN_W(16)) ifm ();
    message_bit_serializer_if #(.LEN_W(16)) ifl ();

    assign ifm.in_start      = start;
    assign ifm.in_length     = length;
    assign ifm.in_byte       = byte_in;
    assign ifm.in_byte_valid = valid;
    assign ifm.in_bit_req    = req;
    assign ifl.in_start      = start;
    assign ifl.in_length     = length;
    assign ifl.in_byte       = byte_in;
    assign ifl.in_byte_valid = valid;
    assign ifl.in_bit_req    = req;

    message_bit_serializer #(.DEPTH(16), .LEN_W(16), .MSB_FIRST(1'b1)) dut_msb (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (ifm)
    );

    message_bit_serializer #(.DEPTH(16), .LEN_W(16), .MSB_FIRST(1'b0)) dut_lsb (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (ifl)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] len);
        start  = 1'b1;
        length = len;
        tick();
        start  = 1'b0;
    endtask

    task automatic push(input byte_t b);
        int n = 0;
        byte_in = b;
        valid   = 1'b1;
        while (!ifm.out_byte_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("push_timeout", 32'(ifm.out_byte_ready), 32'd1);
        tick();
        valid = 1'b0;
    endtask

    task automatic req_bit(input byte_t b, input int i);
        qm.push_back('{under: 1'b0, bitv: b[7-i]});
        ql.push_back('{under: 1'b0, bitv: b[i]});
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
    endtask

    task automatic req_byte(input byte_t b);
        for (int i = 0; i < 8; i++) req_bit(b, i);
    endtask

    task automatic req_under();
        qm.push_back('{under: 1'b1, bitv: 1'b0});
        ql.push_back('{under: 1'b1, bitv: 1'b0});
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifm.out_bit_valid || ifm.out_underrun) begin
                chk("msb_valid_xor_underrun", 32'(ifm.out_bit_valid & ifm.out_underrun), 32'd0);
                if (qm.size() == 0) begin
                    chk("msb_unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = qm.pop_front();
                    chk("msb_underrun", 32'(ifm.out_underrun), 32'(e.under));
                    chk("msb_bit", 32'(ifm.out_message), 32'(e.bitv));
                end
            end
            if (ifl.out_bit_valid || ifl.out_underrun) begin
                chk("lsb_valid_xor_underrun", 32'(ifl.out_bit_valid & ifl.out_underrun), 32'd0);
                if (ql.size() == 0) begin
                    chk("lsb_unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = ql.pop_front();
                    chk("lsb_underrun", 32'(ifl.out_underrun), 32'(e.under));
                    chk("lsb_bit", 32'(ifl.out_message), 32'(e.bitv));
                end
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready_m"}, 32'(ifm.out_byte_ready), 32'd1);
        chk({tag, "_ready_l"}, 32'(ifl.out_byte_ready), 32'd1);
        chk({tag, "_done"},    32'(ifm.out_done), 32'd0);
        chk({tag, "_busy"},    32'(ifm.out_busy), 32'd0);
        chk({tag, "_msg"},     32'(ifm.out_message | ifl.out_message), 32'd0);
        chk({tag, "_valid"},   32'(ifm.out_bit_valid | ifl.out_bit_valid), 32'd0);
        chk({tag, "_under"},   32'(ifm.out_underrun | ifl.out_underrun), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        fork
            monitor();
        join_none

        rst = 1'b1;
        repeat (3) tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();

        // A5 is a bit palindrome, so both orders expect 1,0,1,0,0,1,0,1
        do_start(16'd1);
        chk("t1_busy", 32'(ifm.out_busy), 32'd1);
        push(8'hA5);
        tick();
        tick();
        for (int i = 0; i < 7; i++) req_bit(8'hA5, i);
        chk("t1_done_early", 32'(ifm.out_done), 32'd0);
        req_bit(8'hA5, 7);
        chk("t1_done", 32'(ifm.out_done), 32'd1);
        chk("t1_busy_end", 32'(ifm.out_busy), 32'd0);

        do_start(16'd1);
        chk("t2_done_clear", 32'(ifl.out_done), 32'd0);
        push(8'h01);
        tick();
        tick();
        req_byte(8'h01);
        chk("t2_done", 32'(ifl.out_done), 32'd1);

        do_start(16'd2);
        push(8'h3C);
        tick();
        tick();
        req_byte(8'h3C);
        req_under();
        chk("t3_busy", 32'(ifm.out_busy), 32'd1);
        chk("t3_not_done", 32'(ifm.out_done), 32'd0);
        push(8'hC3);
        tick();
        tick();
        req_byte(8'hC3);
        chk("t3_done", 32'(ifm.out_done), 32'd1);

        do_start(16'd0);
        chk("t5_done", 32'(ifm.out_done), 32'd1);
        chk("t5_busy", 32'(ifm.out_busy), 32'd0);
        req_under();
        chk("t5_done_held", 32'(ifm.out_done), 32'd1);

        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        chk("t4_full_m", 32'(ifm.out_byte_ready), 32'd0);
        chk("t4_full_l", 32'(ifl.out_byte_ready), 32'd0);
        byte_in = 8'h20;
        valid   = 1'b1;
        repeat (3) tick();
        chk("t4_held_off", 32'(ifm.out_byte_ready), 32'd0);
        do_start(16'd1);
        n = 0;
        while (!ifm.out_byte_ready && n < 10) begin
            tick();
            n++;
        end
        chk("t4_ready_after_pop", 32'(ifm.out_byte_ready), 32'd1);
        tick();
        valid = 1'b0;
        chk("t4_17th_taken", 32'(ifm.out_byte_ready), 32'd0);
        req_byte(8'h10);
        chk("t4_done_first", 32'(ifm.out_done), 32'd1);
        do_start(16'd16);
        tick();
        tick();
        for (int i = 1; i < 16; i++) req_byte(8'(8'h10 + i));
        req_byte(8'h20);
        chk("t4_done_all", 32'(ifm.out_done), 32'd1);
        chk("t4_drained", 32'(ifm.out_byte_ready), 32'd1);

        do_start(16'd4);
        push(8'hF0);
        push(8'h0F);
        push(8'h99);
        push(8'h66);
        tick();
        tick();
        for (int i = 0; i < 3; i++) req_bit(8'hF0, i);
        rst = 1'b1;
        tick();
        chk_idle("t6_reset");
        rst = 1'b0;
        tick();
        do_start(16'd1);
        push(8'h5A);
        tick();
        tick();
        req_byte(8'h5A);
        chk("t6_done", 32'(ifm.out_done), 32'd1);

        repeat (5) tick();
        chk("queue_m_empty", 32'(qm.size()), 32'd0);
        chk("queue_l_empty", 32'(ql.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
